// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the LEGv8 immediate extractor pipeline.
// Holds the format tag enum, the opcode match patterns and the field widths
// of each immediate-bearing instruction format.
package imm_ext_pkg;

  // Width of the format tag carried alongside each immediate.
  localparam int IMM_FMT_W = 3;

  // Format tag values as seen on out_fmt.
  typedef enum logic [IMM_FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_B    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  // D format: instr[31:21]
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CB format: instr[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  // B format: instr[31:26]
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  // I format: instr[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // IW format: instr[31:23]
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  // Immediate field widths per format.
  localparam int W_D  = 9;
  localparam int W_CB = 19;
  localparam int W_B  = 26;
  localparam int W_I  = 12;
  localparam int W_IW = 16;

  // Widest immediate the decoder builds internally before truncation.
  localparam int IMM_MAX_W = 64;

  // True for the PC-relative formats whose offsets may be scaled to bytes.
  function automatic logic is_branch(input fmt_e f);
    return (f == FMT_CB) || (f == FMT_B);
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Bundle of the instruction-side and result-side handshakes of imm_ext_pipe.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and its payload stable
// until that edge; ready may depend combinationally on downstream state but
// never on the same side's valid.
interface imm_ext_pipe_if #(
  parameter int DATA_W = 64,
  parameter int FMT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [FMT_W-1:0]  out_fmt;
  logic              out_illegal;

  // Producer of instructions and consumer of results.
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  // The extractor pipeline itself.
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_ext_decode.sv
// Combinational LEGv8 immediate decoder: classifies the instruction format,
// extracts the immediate field and extends it to DATA_W bits.
// Build option: IMM_EXT_BRANCH_SHIFT_EN scales CB/B offsets to bytes (<<2).
module imm_ext_decode
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64   // legal range 32..64
) (
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] imm,
  output fmt_e              fmt,
  output logic              illegal
);

  logic [IMM_MAX_W-1:0] d_ext;
  logic [IMM_MAX_W-1:0] cb_ext;
  logic [IMM_MAX_W-1:0] b_ext;
  logic [IMM_MAX_W-1:0] i_ext;
  logic [IMM_MAX_W-1:0] iw_ext;
  logic [IMM_MAX_W-1:0] cb_val;
  logic [IMM_MAX_W-1:0] b_val;
  logic [IMM_MAX_W-1:0] raw;

  // Extend to the full 64 bits first; truncating to DATA_W afterwards keeps
  // the field MSB replicated up to bit DATA_W-1.
  assign d_ext  = {{(IMM_MAX_W-W_D){instr[20]}},  instr[20:12]};
  assign cb_ext = {{(IMM_MAX_W-W_CB){instr[23]}}, instr[23:5]};
  assign b_ext  = {{(IMM_MAX_W-W_B){instr[25]}},  instr[25:0]};
  assign i_ext  = {{(IMM_MAX_W-W_I){1'b0}},       instr[21:10]};
  // MOVZ: hw selects a 16-bit lane, shift = hw*16.
  assign iw_ext = {{(IMM_MAX_W-W_IW){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};

`ifdef IMM_EXT_BRANCH_SHIFT_EN
  // Byte offsets: the two MSBs of the pre-shift value fall off the top after
  // truncation to DATA_W.
  assign cb_val = cb_ext << 2;
  assign b_val  = b_ext << 2;
`else
  // Word offsets, exactly as extended.
  assign cb_val = cb_ext;
  assign b_val  = b_ext;
`endif

  // First-match format decode and immediate selection.
  always_comb begin
    raw     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      raw = d_ext;
      fmt = FMT_D;
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      raw = cb_val;
      fmt = FMT_CB;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      raw = b_val;
      fmt = FMT_B;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      raw = i_ext;
      fmt = FMT_I;
    end else if (instr[31:23] == OP_MOVZ) begin
      fmt = FMT_IW;
      // A 32-bit datapath cannot hold lanes 2 and 3.
      if (DATA_W == 32 && instr[22]) begin
        raw     = '0;
        illegal = 1'b1;
      end else begin
        raw = iw_ext;
      end
    end else begin
      illegal = 1'b1;
    end
  end

  assign imm = raw[DATA_W-1:0];

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage elastic immediate extractor for the LEGv8 datapath.
// S1 captures the instruction word, S2 captures the decoded immediate.
// Build option: IMM_EXT_BRANCH_SHIFT_EN (byte-scaled CB/B offsets, see
// imm_ext_decode).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64,        // legal range 32..64
  parameter int FMT_W  = IMM_FMT_W
) (
  input  logic         clk,
  input  logic         reset,       // asynchronous, active low
  imm_ext_pipe_if.slave bus
);

  logic              s1_valid;
  logic [31:0]       s1_instr;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_imm;
  fmt_e              s2_fmt;
  logic              s2_illegal;

  logic [DATA_W-1:0] dec_imm;
  fmt_e              dec_fmt;
  logic              dec_illegal;

  logic              s2_load;
  logic              s1_move;

  // S2 can take a new entry when empty or when its current entry leaves.
  assign s2_load = !s2_valid | (s2_valid & bus.out_ready);
  // S1 drains into S2 whenever S2 can load.
  assign s1_move = s1_valid & s2_load;
  // S1 can accept when empty or emptying this cycle.
  assign bus.in_ready = !s1_valid | s1_move;

  imm_ext_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .instr   (s1_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Stage 1: capture the instruction word on an accepted transfer only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_instr <= bus.in_instr;
      end
    end
  end

  // Stage 2: capture the decoded result; payload is frozen while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      s2_imm     <= '0;
      s2_fmt     <= FMT_NONE;
      s2_illegal <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_imm     <= dec_imm;
        s2_fmt     <= dec_fmt;
        s2_illegal <= dec_illegal;
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_imm     = s2_imm;
  assign bus.out_fmt     = FMT_W'(s2_fmt);
  assign bus.out_illegal = s2_illegal;

endmodule
